// File: rtl/memdr_responder.sv
// Memory-side responder for the directory-to-memory channels: a line-granular backing
// store, an in-order read queue that acks after a fixed latency, and a prefetch counter.
package memdr_pkg;
  localparam int DR_REQIDBITS = 6;
  localparam int PADDR_BITS   = 50;

  typedef enum logic [2:0] {
    SC_CMD_REQ_S = 3'd0,
    SC_CMD_REQ_M = 3'd1
  } sc_cmd_e;

  typedef enum logic [2:0] {
    SC_SCMD_ACK_S = 3'd0,
    SC_SCMD_ACK_E = 3'd1
  } sc_ack_e;

  typedef struct packed {
    logic [PADDR_BITS-1:0]   paddr;
    sc_cmd_e                 cmd;
    logic [DR_REQIDBITS-1:0] drid;
  } I_drtomem_req_type;

  typedef struct packed {
    logic [DR_REQIDBITS-1:0] drid;
    sc_ack_e                 ack;
    logic [511:0]            line;
  } I_memtodr_ack_type;

  typedef struct packed {
    logic [PADDR_BITS-1:0] paddr;
    logic [511:0]          line;
  } I_drtomem_wb_type;

  typedef struct packed {
    logic [PADDR_BITS-1:0] paddr;
  } I_drtomem_pfreq_type;
endpackage

module memdr_responder
  import memdr_pkg::*;
#(
  parameter int Lines   = 64,
  parameter int Latency = 4,
  parameter int QDepth  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                drtomem_req_valid,
  output logic                drtomem_req_retry,
  input  I_drtomem_req_type   drtomem_req,
  output logic                memtodr_ack_valid,
  input  logic                memtodr_ack_retry,
  output I_memtodr_ack_type   memtodr_ack,
  input  logic                drtomem_wb_valid,
  output logic                drtomem_wb_retry,
  input  I_drtomem_wb_type    drtomem_wb,
  input  logic                drtomem_pfreq_valid,
  output logic                drtomem_pfreq_retry,
  input  I_drtomem_pfreq_type drtomem_pfreq,
  output logic [15:0]         pf_count
);
  localparam int IdxW = $clog2(Lines);
  localparam int PtrW = $clog2(QDepth);
  localparam int CntW = $clog2(QDepth + 1);
  localparam int TmW  = $clog2(Latency + 1);

  logic [511:0]      store_mem [Lines];
  I_memtodr_ack_type q_mem     [QDepth];

  logic [Lines-1:0]  written_q, written_d;
  logic [TmW-1:0]    timer_q [QDepth];
  logic [TmW-1:0]    timer_d [QDepth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [15:0]       pf_count_q, pf_count_d;

  logic              req_fire, ack_fire, wb_fire, pf_fire;
  logic [IdxW-1:0]   req_idx, wb_idx;
  logic [511:0]      req_line;
  I_memtodr_ack_type push_entry;
  logic              unused_inputs;

  assign req_idx = drtomem_req.paddr[6 +: IdxW];
  assign wb_idx  = drtomem_wb.paddr[6 +: IdxW];

  // Request retry comes only from the registered occupancy, never from req_valid.
  assign drtomem_req_retry   = (count_q == CntW'(QDepth));
  assign drtomem_wb_retry    = 1'b0;
  assign drtomem_pfreq_retry = 1'b0;

  assign memtodr_ack_valid = (count_q != '0) && (timer_q[rd_ptr_q] == '0);
  assign memtodr_ack       = q_mem[rd_ptr_q];
  assign pf_count          = pf_count_q;

  assign req_fire = drtomem_req_valid && !drtomem_req_retry;
  assign ack_fire = memtodr_ack_valid && !memtodr_ack_retry;
  assign wb_fire  = drtomem_wb_valid;
  assign pf_fire  = drtomem_pfreq_valid;

  assign unused_inputs = ^{drtomem_pfreq, drtomem_req.paddr, drtomem_wb.paddr};

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    written_d  = written_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pf_count_d = pf_count_q;

    // A same-cycle writeback to the requested line wins over the stored copy.
    req_line = written_q[req_idx] ? store_mem[req_idx] : '0;
    if (wb_fire && (wb_idx == req_idx)) req_line = drtomem_wb.line;

    push_entry.drid = drtomem_req.drid;
    push_entry.ack  = (drtomem_req.cmd == SC_CMD_REQ_M) ? SC_SCMD_ACK_E : SC_SCMD_ACK_S;
    push_entry.line = req_line;

    for (int i = 0; i < QDepth; i++) begin
      timer_d[i] = (timer_q[i] != '0) ? timer_q[i] - TmW'(1) : timer_q[i];
    end

    if (req_fire) begin
      timer_d[wr_ptr_q] = TmW'(Latency - 1);
      wr_ptr_d          = wr_ptr_q + PtrW'(1);
    end
    if (ack_fire) rd_ptr_d = rd_ptr_q + PtrW'(1);
    count_d = count_q + CntW'(req_fire) - CntW'(ack_fire);

    if (wb_fire) written_d[wb_idx] = 1'b1;
    if (pf_fire && (pf_count_q != 16'hFFFF)) pf_count_d = pf_count_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      written_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pf_count_q <= '0;
      for (int i = 0; i < QDepth; i++) timer_q[i] <= '0;
    end else begin
      written_q  <= written_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pf_count_q <= pf_count_d;
      timer_q    <= timer_d;
    end
  end

  // NOTE: storage arrays carry no reset; validity lives in written_q and count_q.
  always_ff @(posedge clk) begin
    if (wb_fire)  store_mem[wb_idx] <= drtomem_wb.line;
    if (req_fire) q_mem[wr_ptr_q]   <= push_entry;
  end
endmodule

// File: doc/memdr_responder.md
Name: memdr_responder

Overview:
- Main-memory-side responder for the directory-to-memory interface. It is the other end of the drtomem_req, memtodr_ack, drtomem_wb and drtomem_pfreq channels.
- Holds a small line-granular backing store. Accepts writebacks into it, and answers each read request with a memtodr_ack carrying the request's drid after a fixed latency.
- Serves as the memory endpoint for directory-bank passthrough and integration benches. Synthesizable.

Parameters:
- Lines, 64: backing-store lines (power of 2). Index = paddr[6 +: log2(Lines)]; 64 B lines.
- Latency, 4: cycles from request acceptance to earliest ack valid. Must be ≥ 1.
- QDepth, 4: outstanding read requests held (power of 2).

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- drtomem_req_valid, in, 1: read request valid.
- drtomem_req_retry, out, 1: request backpressure.
- drtomem_req, in, I_drtomem_req_type: paddr, cmd, drid (`DR_REQIDBITS).
- memtodr_ack_valid, out, 1: ack valid.
- memtodr_ack_retry, in, 1: ack backpressure.
- memtodr_ack, out, I_memtodr_ack_type: drid, ack, line (512).
- drtomem_wb_valid, in, 1: writeback valid.
- drtomem_wb_retry, out, 1: writeback backpressure.
- drtomem_wb, in, I_drtomem_wb_type: paddr, line (512).
- drtomem_pfreq_valid, in, 1: prefetch valid.
- drtomem_pfreq_retry, out, 1: prefetch backpressure.
- drtomem_pfreq, in, I_drtomem_pfreq_type: paddr.
- pf_count, out, 16: prefetches consumed, saturating.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Handshake:
  - A channel transfers when valid && !retry.
  - Outputs held under retry stay stable (valid and payload) until taken.
  - No retry depends combinationally on the same channel's valid.
- Reset values:
  - memtodr_ack_valid = 0, pf_count = 0.
  - drtomem_req_retry = 0, drtomem_wb_retry = 0, drtomem_pfreq_retry = 0.
  - Queue empty; all line-written bits cleared.
  - Store data is not reset. A read of a line whose written bit is 0 returns 512'b0.
- Writeback:
  - drtomem_wb_retry is tied 0.
  - On transfer, line[idx] <= wb.line and written[idx] <= 1 at the clock edge.
  - No ack is returned.
- Read request:
  - drtomem_req_retry = queue full (registered count == QDepth).
  - On transfer, push {drid, cmd, data snapshot, timer = Latency - 1}. Data = store[idx], or 0 if unwritten.
  - A writeback transferring in the same cycle to the same idx is forwarded: the snapshot takes wb.line.
  - Each entry's timer decrements every cycle while nonzero, independent of backpressure.
- Ack:
  - The head entry drives memtodr_ack_valid when its timer == 0.
  - Payload: drid echoed; line = snapshot; ack = ack encoding for cmd per scmem.vh (shared read -> shared ack, exclusive read -> exclusive ack).
  - Pop on transfer. Strictly in acceptance order.
  - A request accepted at cycle t has ack valid no earlier than t + Latency. With an empty queue and no retry it is exactly t + Latency.
- Simultaneous push and pop: allowed in the same cycle; count is unchanged.
  - When full, a pop frees a slot only in the next cycle, because retry is registered from count.
- Prefetch:
  - drtomem_pfreq_retry is tied 0.
  - Each transfer increments pf_count, saturating at 16'hFFFF. No store or queue effect.
- Wrap-around:
  - Queue pointers wrap modulo QDepth.
  - paddr bits above the index are ignored (aliasing is permitted).
- Reset mid-operation: queued entries are discarded with no ack, ack_valid drops the next cycle, and written bits are cleared.

Test Plan:
- Reset, then req paddr 0x40, drid 5, shared read, at t=10 -> ack valid at t=14: drid 5, line 0, shared ack.
- wb paddr 0x80, line = {16{32'hDEADBEEF}}, then req drid 9 to 0x80 -> ack drid 9 returns that line. Same-cycle wb + req to 0xC0 -> the ack carries the new wb data.
- Hold memtodr_ack_retry=1 while issuing 5 reqs (drids 1–5), QDepth 4 -> the 5th sees req_retry=1. Release retry -> acks drid 1,2,3,4,5 in order, each payload held stable while under retry.
- Back-to-back reqs with ack_retry=0 -> one ack per cycle after the initial 4-cycle latency; a push and pop in the same cycle leaves the count constant.
- 3 prefetches, plus a forced saturation at 16'hFFFF -> pf_count = 3, then holds 16'hFFFF. No ack is ever produced for a prefetch.
- Assert reset with 2 entries queued -> no acks after reset, and a previously written line reads back 0.
